// File: rtl/mire_pkg.sv
// Shared definitions for the grid test-pattern writer: FSM state codes,
// RGB565 colour constants and the grid colour helper.
package mire_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam logic [15:0] PIX_ON  = 16'hFFFF;
  localparam logic [15:0] PIX_OFF = 16'h0000;

  // GRID is a power of two, so the modulo reduces to a mask.
  function automatic logic [15:0] grid_colour(input logic [31:0] x,
                                               input logic [31:0] y,
                                               input logic [31:0] grid);
    logic [31:0] mask;
    mask = grid - 32'd1;
    if (((x & mask) == 32'd0) || ((y & mask) == 32'd0)) begin
      grid_colour = PIX_ON;
    end else begin
      grid_colour = PIX_OFF;
    end
  endfunction

endpackage

// File: rtl/mire_if.sv
// Wishbone classic bus bundle shared by the pattern writer (master) and the
// framebuffer memory (slave).
interface wshb_if #(parameter int DATA_BYTES = 2);

  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic                    ack;
  logic [DATA_BYTES-1:0]   sel;
  logic [31:0]             adr;
  logic [8*DATA_BYTES-1:0] dat_ms;
  logic [8*DATA_BYTES-1:0] dat_sm;
  logic [2:0]              cti;
  logic [1:0]              bte;

  modport master (output cyc, stb, we, sel, adr, dat_ms, cti, bte,
                  input  ack, dat_sm);

  modport slave  (input  cyc, stb, we, sel, adr, dat_ms, cti, bte,
                  output ack, dat_sm);

endinterface

// File: rtl/mire_counter.sv
// Raster position counter: x/y coordinates plus a linear pixel index,
// all advancing together and wrapping together at the end of the frame.
module mire_counter #(
  parameter int HDISP = 640,
  parameter int VDISP = 480,
  parameter int XW    = (HDISP > 1) ? $clog2(HDISP) : 1,
  parameter int YW    = (VDISP > 1) ? $clog2(VDISP) : 1,
  parameter int PW    = (HDISP * VDISP > 1) ? $clog2(HDISP * VDISP) : 1
) (
  input  logic          CLK,
  input  logic          NRST,
  input  logic          adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [PW-1:0] pix,
  output logic          last_pix
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [PW-1:0] pix_q, pix_d;

  // Next raster position on each advance; the linear index avoids a y*HDISP multiply.
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    pix_d = pix_q;
    if (adv) begin
      if (x_q == XW'(HDISP - 1)) begin
        x_d = {XW{1'b0}};
        if (y_q == YW'(VDISP - 1)) begin
          y_d = {YW{1'b0}};
        end else begin
          y_d = y_q + YW'(1);
        end
      end else begin
        x_d = x_q + XW'(1);
        y_d = y_q;
      end
      if (pix_q == PW'(HDISP * VDISP - 1)) begin
        pix_d = {PW{1'b0}};
      end else begin
        pix_d = pix_q + PW'(1);
      end
    end else begin
      x_d   = x_q;
      y_d   = y_q;
      pix_d = pix_q;
    end
  end

  // Position registers.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      x_q   <= {XW{1'b0}};
      y_q   <= {YW{1'b0}};
      pix_q <= {PW{1'b0}};
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      pix_q <= pix_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign pix      = pix_q;
  assign last_pix = (pix_q == PW'(HDISP * VDISP - 1));

endmodule

// File: rtl/mire.sv
// Grid test-pattern generator: streams RGB565 pixels into a framebuffer over
// Wishbone classic writes, yielding the bus for one cycle after every burst.
module mire
  import mire_pkg::*;
#(
  parameter int HDISP     = 640,
  parameter int VDISP     = 480,
  parameter int BURST_LEN = 64,
  parameter int GRID      = 16
) (
  input  logic   CLK,
  input  logic   NRST,
  input  logic   en,
  output logic   frame_done,
  wshb_if.master wshb_ifm
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int PW = (HDISP * VDISP > 1) ? $clog2(HDISP * VDISP) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          frame_done_q, frame_done_d;

  logic          adv_s;
  logic          burst_end_s;
  logic          last_pix_s;
  logic [XW-1:0] x_s;
  logic [YW-1:0] y_s;
  logic [PW-1:0] pix_s;
  logic          unused_s;

  assign adv_s       = (state_q == WRITE) && wshb_ifm.ack;
  assign burst_end_s = (burst_q == BW'(BURST_LEN - 1));

  mire_counter #(
    .HDISP (HDISP),
    .VDISP (VDISP),
    .XW    (XW),
    .YW    (YW),
    .PW    (PW)
  ) u_counter (
    .CLK      (CLK),
    .NRST     (NRST),
    .adv      (adv_s),
    .x        (x_s),
    .y        (y_s),
    .pix      (pix_s),
    .last_pix (last_pix_s)
  );

  // Bus ownership FSM; en is only looked at while the bus is released.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (adv_s && (burst_end_s || last_pix_s)) begin
          state_d = PAUSE;
        end else begin
          state_d = WRITE;
        end
      end
      PAUSE: begin
        if (en) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst length tracking and the end-of-frame pulse.
  always_comb begin
    burst_d      = burst_q;
    frame_done_d = adv_s && last_pix_s;
    if (adv_s) begin
      if (burst_end_s || last_pix_s) begin
        burst_d = {BW{1'b0}};
      end else begin
        burst_d = burst_q + BW'(1);
      end
    end else if (state_q == PAUSE) begin
      burst_d = {BW{1'b0}};
    end else begin
      burst_d = burst_q;
    end
  end

  // Control registers.
  always_ff @(posedge CLK) begin
    if (!NRST) begin
      state_q      <= IDLE;
      burst_q      <= {BW{1'b0}};
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done      = frame_done_q;
  assign wshb_ifm.cyc    = (state_q == WRITE);
  assign wshb_ifm.stb    = (state_q == WRITE);
  assign wshb_ifm.we     = 1'b1;
  assign wshb_ifm.sel    = 2'b11;
  assign wshb_ifm.cti    = 3'b000;
  assign wshb_ifm.bte    = 2'b00;
  assign wshb_ifm.adr    = {{(31 - PW){1'b0}}, pix_s, 1'b0};
  assign wshb_ifm.dat_ms = grid_colour(32'(x_s), 32'(y_s), 32'(GRID));

  // Write-only master: read data is never consumed.
  assign unused_s = ^wshb_ifm.dat_sm;

endmodule

// File: tb/tb_mire.sv
// Directed bench for mire on an 8x4 frame: a Wishbone slave model with
// programmable ack latency and a scoreboard of expected pixel writes.
module tb_mire;

  localparam int HD = 8;
  localparam int VD = 4;
  localparam int BL = 4;
  localparam int GR = 4;

  typedef struct packed {
    logic [31:0] adr;
    logic [15:0] dat;
  } wr_t;

  logic clk = 1'b0;
  logic nrst;
  logic en;
  logic frame_done;
  int   stall;
  int   wait_cnt;
  int   checks = 0;
  int   errors = 0;
  int   fd_count = 0;

  wr_t         exp_q[$];
  logic        pause_pending = 1'b0;
  logic        cont_pending = 1'b0;
  logic        fd_pending = 1'b0;
  logic        prev_wait = 1'b0;
  int          burst_cnt = 0;
  logic [31:0] prev_adr = 32'd0;
  logic [15:0] prev_dat = 16'd0;

  wshb_if #(.DATA_BYTES(2)) bus();

  mire #(.HDISP(HD), .VDISP(VD), .BURST_LEN(BL), .GRID(GR)) dut (
    .CLK        (clk),
    .NRST       (nrst),
    .en         (en),
    .frame_done (frame_done),
    .wshb_ifm   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic wr_t model(input int p);
    wr_t w;
    int  x;
    int  y;
    x     = p % HD;
    y     = p / HD;
    w.adr = 32'(2 * p);
    w.dat = ((x % GR) == 0 || (y % GR) == 0) ? 16'hFFFF : 16'h0000;
    return w;
  endfunction

  task automatic push_range(input int first, input int count);
    for (int i = 0; i < count; i++) exp_q.push_back(model((first + i) % (HD * VD)));
  endtask

  task automatic wait_empty(input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0) begin
        found = 1'b1;
        break;
      end
    end
    chk("writes_drained", 32'(found), 32'd1);
  endtask

  task automatic wait_write(input logic [31:0] a, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (bus.cyc && bus.stb && !bus.ack && bus.adr == a) begin
        found = 1'b1;
        break;
      end
    end
    chk("write_started", 32'(found), 32'd1);
  endtask

  // Slave model: ack after 'stall' extra wait cycles, never back-to-back.
  always @(posedge clk) begin
    if (!nrst) begin
      bus.ack  <= 1'b0;
      wait_cnt <= 0;
    end else if (bus.cyc && bus.stb && !bus.ack) begin
      if (wait_cnt >= stall) begin
        bus.ack  <= 1'b1;
        wait_cnt <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      bus.ack <= 1'b0;
    end
  end

  // Monitor: scoreboard pops, bus release after bursts, stall stability, frame pulse.
  always @(negedge clk) begin
    wr_t w;
    if (!nrst) begin
      pause_pending = 1'b0;
      cont_pending  = 1'b0;
      fd_pending    = 1'b0;
      prev_wait     = 1'b0;
      burst_cnt     = 0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_pending));
      if (frame_done === 1'b1) fd_count++;
      if (pause_pending) chk("pause_cyc", 32'(bus.cyc), 32'd0);
      else if (cont_pending) chk("burst_cont_cyc", 32'(bus.cyc), 32'd1);
      if (prev_wait && bus.cyc) begin
        chk("stall_adr", bus.adr, prev_adr);
        chk("stall_dat", 32'(bus.dat_ms), 32'(prev_dat));
      end
      pause_pending = 1'b0;
      cont_pending  = 1'b0;
      fd_pending    = 1'b0;
      if (bus.cyc && bus.stb && bus.ack) begin
        chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          chk("adr", bus.adr, w.adr);
          chk("dat", 32'(bus.dat_ms), 32'(w.dat));
          chk("we_sel_cti_bte", {24'd0, bus.we, bus.sel, bus.cti, bus.bte}, 32'h0000_00E0);
        end
        burst_cnt++;
        fd_pending = (bus.adr == 32'(2 * (HD * VD - 1)));
        if (burst_cnt == BL || fd_pending) begin
          pause_pending = 1'b1;
          burst_cnt     = 0;
        end else begin
          cont_pending = 1'b1;
        end
        prev_wait = 1'b0;
      end else begin
        prev_wait = bus.cyc && bus.stb;
      end
      prev_adr = bus.adr;
      prev_dat = bus.dat_ms;
    end
  end

  initial begin
    nrst       = 1'b0;
    en         = 1'b1;
    stall      = 0;
    bus.dat_sm = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cyc", 32'(bus.cyc), 32'd0);
    chk("rst_stb", 32'(bus.stb), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_adr", bus.adr, 32'd0);
    chk("rst_dat", 32'(bus.dat_ms), 32'h0000_FFFF);

    // First burst out of reset; en drops during the 2nd write.
    push_range(0, 4);
    nrst = 1'b1;
    wait_write(32'd2, 20);
    en = 1'b0;
    wait_empty(50);
    repeat (4) begin
      @(negedge clk); #1;
      chk("idle_cyc", 32'(bus.cyc), 32'd0);
    end
    chk("idle_adr", bus.adr, 32'd8);

    // Resume at pixel 4, run through the frame wrap into the next frame.
    push_range(4, 32);
    en = 1'b1;
    wait_empty(400);
    chk("fd_count", 32'(fd_count), 32'd1);

    // Slow slave: ack five cycles late.
    stall = 5;
    push_range(4, 4);
    wait_empty(150);
    stall = 0;

    // Reset in the middle of a burst at adr 20.
    push_range(8, 2);
    wait_write(32'd20, 40);
    nrst = 1'b0;
    @(negedge clk); #1;
    chk("rst2_cyc", 32'(bus.cyc), 32'd0);
    chk("rst2_adr", bus.adr, 32'd0);
    chk("rst2_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk); #1;
    push_range(0, 4);
    nrst = 1'b1;
    wait_write(32'd2, 20);
    en = 1'b0;
    wait_empty(50);
    repeat (3) begin
      @(negedge clk); #1;
      chk("final_idle_cyc", 32'(bus.cyc), 32'd0);
    end
    chk("final_fd_count", 32'(fd_count), 32'd1);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
